// File: rtl/string_detector_sched.sv
// string_detector_sched: round-robin frame scheduler for the 4-bit serial
// pattern detector. It grants one requester per frame, streams FRAME_LEN bits
// through a shift/match/lockout datapath, flushes for FLUSH_LEN cycles, then
// holds the match count on a valid/ready result port until it is accepted.
module string_detector_sched #(
  parameter int FRAME_LEN = 20,
  parameter int FLUSH_LEN = 4,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [3:0]       pat_a,
  input  logic [3:0]       pat_b,
  input  logic             bit_a,
  input  logic             bit_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_id,
  output logic             busy
);

  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] LAST_FL  = FW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, REPORT} state_t;

  state_t           state_q;
  logic             ptr_q;      // 0 = favour A, 1 = favour B
  logic             owner_q;    // 0 = A, 1 = B
  logic [3:0]       pat_q;
  logic [3:0]       shreg_q;
  logic [BW-1:0]    bitcnt_q;   // bits already shifted this frame
  logic [FW-1:0]    flcnt_q;
  logic [1:0]       lock_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_a_q, gnt_b_q, res_valid_q, res_id_q, busy_q;
  logic [CNT_W-1:0] res_count_q;

  logic       sel_d;
  logic       bit_own;
  logic [3:0] win_d;
  logic       match_d;

  // Owner selection in IDLE and the match test on the window after this shift
  always_comb begin
    sel_d   = (req_a && req_b) ? ptr_q : req_b;
    bit_own = owner_q ? bit_b : bit_a;
    win_d   = {shreg_q[2:0], bit_own};
    match_d = (win_d == pat_q) && (bitcnt_q >= BW'(3)) && (lock_q == 2'd0);
  end

  // Frame FSM with registered grant/result/busy outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      pat_q       <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      flcnt_q     <= '0;
      lock_q      <= '0;
      cnt_q       <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_a || req_b) begin
            owner_q  <= sel_d;
            pat_q    <= sel_d ? pat_b : pat_a;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            lock_q   <= '0;
            cnt_q    <= '0;
            gnt_a_q  <= ~sel_d;
            gnt_b_q  <= sel_d;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          shreg_q  <= win_d;
          bitcnt_q <= bitcnt_q + BW'(1);
          if (match_d) begin
            cnt_q  <= (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            lock_q <= 2'd3;
          end else if (lock_q != 2'd0) begin
            lock_q <= lock_q - 2'd1;
          end
          if (bitcnt_q == LAST_BIT) begin
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            flcnt_q <= '0;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          shreg_q <= '0;
          if (flcnt_q == LAST_FL) begin
            res_valid_q <= 1'b1;
            res_count_q <= cnt_q;
            res_id_q    <= owner_q;
            state_q     <= REPORT;
          end else begin
            flcnt_q <= flcnt_q + FW'(1);
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            ptr_q       <= ~owner_q;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign res_valid = res_valid_q;
  assign res_count = res_count_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_string_detector_sched.sv
// Directed bench for string_detector_sched: frame timing, match counting,
// lockout, round-robin order, result back-pressure and mid-frame reset.
module tb_string_detector_sched;
  localparam int FRAME_LEN = 20;
  localparam int FLUSH_LEN = 4;
  localparam int CNT_W     = 5;

  logic clk = 1'b0;
  logic rst_n, req_a, req_b, bit_a, bit_b, res_ready;
  logic [3:0] pat_a, pat_b;
  logic gnt_a, gnt_b, res_valid, res_id, busy;
  logic [CNT_W-1:0] res_count;

  int checks = 0;
  int errors = 0;

  string_detector_sched #(.FRAME_LEN(FRAME_LEN), .FLUSH_LEN(FLUSH_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .pat_a(pat_a), .pat_b(pat_b),
    .bit_a(bit_a), .bit_b(bit_b), .gnt_a(gnt_a), .gnt_b(gnt_b), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a frame for one requester and feed its bits (MSB first) whenever
  // its grant is high; return once res_valid is seen or the budget expires.
  task automatic drive_frame(input logic id, input logic [3:0] pat,
                             input logic [FRAME_LEN-1:0] bits,
                             output int gcyc, output int lat, output logic ovl);
    int idx;
    idx = 0; gcyc = 0; lat = 0; ovl = 1'b0;
    if (id) begin pat_b = pat; req_b = 1'b1; end
    else    begin pat_a = pat; req_a = 1'b1; end
    while (lat < 200) begin
      tick();
      lat++;
      if (gnt_a && gnt_b) ovl = 1'b1;
      if (id ? gnt_b : gnt_a) begin
        if (id) req_b = 1'b0; else req_a = 1'b0;
        if (idx < FRAME_LEN) begin
          if (id) bit_b = bits[FRAME_LEN-1-idx];
          else    bit_a = bits[FRAME_LEN-1-idx];
        end
        idx++;
        gcyc++;
      end
      if (res_valid) break;
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin errors++; $display("FAIL reset_gnt: got a=%b b=%b expected 0 0", gnt_a, gnt_b); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    checks++; if (res_count !== '0 || res_id !== 1'b0) begin errors++; $display("FAIL reset_res: got count=%0d id=%b expected 0 0", res_count, res_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_ones();
    int g, l; logic o;
    drive_frame(1'b0, 4'b1111, '1, g, l, o);
    checks++; if (g != 20) begin errors++; $display("FAIL ones_gnt_cycles: got %0d expected 20", g); end
    checks++; if (l != 25) begin errors++; $display("FAIL ones_latency: got %0d expected 25", l); end
    checks++; if (res_count !== 5'd5) begin errors++; $display("FAIL ones_count: got %0d expected 5", res_count); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL ones_id: got %b expected 0", res_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ones_busy: got %b expected 1", busy); end
    accept();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ones_accept: got valid=%b busy=%b expected 0 0", res_valid, busy); end
  endtask

  task automatic test_alternating();
    int g, l; logic o;
    drive_frame(1'b0, 4'b1010, 20'hAAAAA, g, l, o);
    checks++; if (res_count !== 5'd5) begin errors++; $display("FAIL alt_count: got %0d expected 5", res_count); end
    accept();
  endtask

  task automatic test_lockout();
    int g, l; logic o;
    drive_frame(1'b0, 4'b0100, 20'hA8000, g, l, o);
    checks++; if (res_count !== 5'd1) begin errors++; $display("FAIL lockout_count: got %0d expected 1", res_count); end
    accept();
  endtask

  task automatic test_b_nomatch();
    int g, l; logic o;
    drive_frame(1'b1, 4'b0000, '1, g, l, o);
    checks++; if (res_count !== 5'd0) begin errors++; $display("FAIL b_count: got %0d expected 0", res_count); end
    checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL b_id: got %b expected 1", res_id); end
    checks++; if (g != 20) begin errors++; $display("FAIL b_gnt_cycles: got %0d expected 20", g); end
    accept();
  endtask

  task automatic test_round_robin();
    int n; logic ovl;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pat_a = 4'b1111; pat_b = 4'b0000; bit_a = 1'b1; bit_b = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    ovl = 1'b0; n = 0;
    while (n < 200 && !res_valid) begin
      tick(); n++;
      if (gnt_a && gnt_b) ovl = 1'b1;
      if (gnt_a) req_a = 1'b0;
    end
    checks++; if (res_valid !== 1'b1 || res_id !== 1'b0) begin errors++; $display("FAIL rr_first: got valid=%b id=%b expected 1 0", res_valid, res_id); end
    checks++; if (res_count !== 5'd5) begin errors++; $display("FAIL rr_first_count: got %0d expected 5", res_count); end
    accept();
    checks++; if (gnt_b !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_idle_gap: got gnt_b=%b busy=%b expected 0 0", gnt_b, busy); end
    tick();
    checks++; if (gnt_b !== 1'b1) begin errors++; $display("FAIL rr_next_grant: got %b expected 1", gnt_b); end
    req_b = 1'b0;
    n = 0;
    while (n < 200 && !res_valid) begin
      tick(); n++;
      if (gnt_a && gnt_b) ovl = 1'b1;
    end
    checks++; if (res_valid !== 1'b1 || res_id !== 1'b1 || res_count !== 5'd0) begin errors++; $display("FAIL rr_second: got valid=%b id=%b count=%0d expected 1 1 0", res_valid, res_id, res_count); end
    checks++; if (ovl !== 1'b0) begin errors++; $display("FAIL rr_gnt_overlap: got %b expected 0", ovl); end
    accept();
  endtask

  task automatic test_backpressure();
    int g, l; logic o; logic stable; logic nognt;
    drive_frame(1'b0, 4'b1111, '1, g, l, o);
    req_b = 1'b1; pat_b = 4'b0000;
    stable = 1'b1; nognt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_count !== 5'd5 || res_id !== 1'b0) stable = 1'b0;
      if (gnt_a || gnt_b) nognt = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b expected 1", stable); end
    checks++; if (nognt !== 1'b1) begin errors++; $display("FAIL bp_no_grant: got %b expected 1", nognt); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; req_b = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got %b expected 0", res_valid); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int n, g, l; logic o;
    pat_a = 4'b1111; bit_a = 1'b1; req_a = 1'b1;
    n = 0; g = 0;
    while (n < 100 && g < 10) begin
      tick(); n++;
      if (gnt_a) begin req_a = 1'b0; g++; end
    end
    rst_n = 1'b0;
    tick();
    checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || res_valid !== 1'b0 || res_count !== '0 || res_id !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs: got gnt=%b%b valid=%b count=%0d id=%b busy=%b expected all 0", gnt_a, gnt_b, res_valid, res_count, res_id, busy); end
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (res_valid || busy) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL midrst_discard: got %0d active cycles expected 0", n); end
    drive_frame(1'b0, 4'b1111, '1, g, l, o);
    checks++; if (g != 20 || l != 25) begin errors++; $display("FAIL midrst_fresh_frame: got gnt=%0d lat=%0d expected 20 25", g, l); end
    checks++; if (res_count !== 5'd5) begin errors++; $display("FAIL midrst_count: got %0d expected 5", res_count); end
    accept();
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    pat_a = 4'b0; pat_b = 4'b0; res_ready = 1'b0;
    test_reset();
    test_all_ones();
    test_alternating();
    test_lockout();
    test_b_nomatch();
    test_round_robin();
    test_backpressure();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
